// File: rtl/simulador_drone_pkg.sv
// Shared constants for the drone game: FSM state codes, mode codes and obstacle maps.
package simulador_drone_pkg;

  // FSM state codes (also exported on db_estado)
  localparam logic [3:0] ST_INICIAL       = 4'd0;
  localparam logic [3:0] ST_ESCOLHE_MODO  = 4'd1;
  localparam logic [3:0] ST_ESCOLHE_VIDAS = 4'd2;
  localparam logic [3:0] ST_PREPARA       = 4'd3;
  localparam logic [3:0] ST_VOO           = 4'd4;
  localparam logic [3:0] ST_MOVE          = 4'd5;
  localparam logic [3:0] ST_VERIFICA      = 4'd6;
  localparam logic [3:0] ST_VENCEU        = 4'd8;
  localparam logic [3:0] ST_PERDEU        = 4'd9;

  // Difficulty mode codes
  localparam logic [1:0] MODO_FACIL   = 2'b00;
  localparam logic [1:0] MODO_MEDIO   = 2'b01;
  localparam logic [1:0] MODO_DIFICIL = 2'b10;

  // Row value meaning "no obstacle in this column"
  localparam logic [3:0] OBST_LIVRE = 4'hF;

  // Obstacle maps: nibble c (bits 4c+3..4c) holds the obstacle row of column c.
  // Easy: col3=7, col6=9, col9=7, col12=5.
  localparam logic [63:0] MAPA_FACIL   = 64'hFFF5_FF7F_F9FF_7FFF;
  // Medium: easy map plus col5=7, col10=8, col14=7.
  localparam logic [63:0] MAPA_MEDIO   = 64'hF7F5_F87F_F97F_7FFF;
  // Hard: every odd column at row 7, col8=6.
  localparam logic [63:0] MAPA_DIFICIL = 64'h7F7F_7F76_7F7F_7F7F;

  // Extract the obstacle nibble of one column from a packed map
  function automatic logic [3:0] obst_lookup(input logic [63:0] mapa, input logic [3:0] coluna);
    return mapa[{coluna, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/drone_obstaculos_rom.sv
// Combinational obstacle lookup: mode + column -> obstacle row (F = free).
module drone_obstaculos_rom
  import simulador_drone_pkg::*;
(
  input  logic [1:0] modo,
  input  logic [3:0] coluna,
  output logic [3:0] obstaculo
);

  logic [3:0] tab_facil   [16];
  logic [3:0] tab_medio   [16];
  logic [3:0] tab_dificil [16];

  // Unpack the three packed maps into per-column tables
  for (genvar gi = 0; gi < 16; gi++) begin : g_tab
    assign tab_facil[gi]   = obst_lookup(MAPA_FACIL,   4'(gi));
    assign tab_medio[gi]   = obst_lookup(MAPA_MEDIO,   4'(gi));
    assign tab_dificil[gi] = obst_lookup(MAPA_DIFICIL, 4'(gi));
  end

  // Select the table of the active mode; the unused code 11 reads the easy map
  always_comb begin
    obstaculo = OBST_LIVRE;
    case (modo)
      MODO_MEDIO:   obstaculo = tab_medio[coluna];
      MODO_DIFICIL: obstaculo = tab_dificil[coluna];
      default:      obstaculo = tab_facil[coluna];
    endcase
  end

endmodule

// File: rtl/simulador_drone.sv
// Drone game core: mode/lives selection, timed column stepping, steering and collision check.
module simulador_drone
  import simulador_drone_pkg::*;
#(
  parameter int TICK_FACIL   = 2000,
  parameter int TICK_MEDIO   = 1000,
  parameter int TICK_DIFICIL = 500,
  parameter int VERT_INICIAL = 7,
  parameter int COLUNA_FINAL = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [1:0] controle,
  input  logic       confirma,
  output logic       venceu,
  output logic       perdeu,
  output logic [3:0] db_posicao_horizontal,
  output logic [3:0] db_posicao_vertical,
  output logic [3:0] db_obstaculos,
  output logic [3:0] db_estado,
  output logic [1:0] db_modo,
  output logic [2:0] colisao_counter_out
);

  logic [3:0]  estado_reg;
  logic [3:0]  horizontal_reg;
  logic [3:0]  vertical_reg;
  logic [2:0]  colisoes_reg;
  logic [2:0]  vidas_reg;
  logic [1:0]  modo_reg;
  logic [11:0] tick_reg;
  logic        confirma_d;
  logic        controle0_d;

  logic        confirma_rise;
  logic        controle0_rise;
  logic [11:0] tick_fim;
  logic [3:0]  obstaculo;
  logic        colisao;
  logic [2:0]  colisoes_next;

  drone_obstaculos_rom u_rom (
    .modo      (modo_reg),
    .coluna    (horizontal_reg),
    .obstaculo (obstaculo)
  );

  assign confirma_rise  = confirma & ~confirma_d;
  assign controle0_rise = controle[0] & ~controle0_d;

  // Last tick count of the flight phase for the selected difficulty
  always_comb begin
    tick_fim = 12'(TICK_FACIL - 1);
    case (modo_reg)
      MODO_MEDIO:   tick_fim = 12'(TICK_MEDIO - 1);
      MODO_DIFICIL: tick_fim = 12'(TICK_DIFICIL - 1);
      default:      tick_fim = 12'(TICK_FACIL - 1);
    endcase
  end

  // Collision test against the column the drone has just moved into
  always_comb begin
    colisao       = (obstaculo != OBST_LIVRE) && (obstaculo == vertical_reg);
    colisoes_next = colisoes_reg + 3'(colisao);
  end

  // Game FSM and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_reg     <= ST_INICIAL;
      horizontal_reg <= 4'd0;
      vertical_reg   <= 4'(VERT_INICIAL);
      colisoes_reg   <= 3'd0;
      vidas_reg      <= 3'd1;
      modo_reg       <= MODO_FACIL;
      tick_reg       <= 12'd0;
      confirma_d     <= 1'b0;
      controle0_d    <= 1'b0;
    end else begin
      confirma_d  <= confirma;
      controle0_d <= controle[0];
      case (estado_reg)
        ST_INICIAL: begin
          if (iniciar) estado_reg <= ST_ESCOLHE_MODO;
        end
        ST_ESCOLHE_MODO: begin
          if (confirma_rise) begin
            modo_reg   <= (controle == 2'b11) ? MODO_FACIL : controle;
            vidas_reg  <= 3'd1;
            estado_reg <= ST_ESCOLHE_VIDAS;
          end
        end
        ST_ESCOLHE_VIDAS: begin
          // a lives pulse coinciding with the confirm still counts
          if (controle0_rise && (vidas_reg != 3'd7)) vidas_reg <= vidas_reg + 3'd1;
          if (confirma_rise) estado_reg <= ST_PREPARA;
        end
        ST_PREPARA: begin
          horizontal_reg <= 4'd0;
          vertical_reg   <= 4'(VERT_INICIAL);
          colisoes_reg   <= 3'd0;
          tick_reg       <= 12'd0;
          estado_reg     <= ST_VOO;
        end
        ST_VOO: begin
          if (tick_reg == tick_fim) estado_reg <= ST_MOVE;
          else                      tick_reg   <= tick_reg + 12'd1;
        end
        ST_MOVE: begin
          horizontal_reg <= horizontal_reg + 4'd1;
          if (controle == 2'b10 && vertical_reg != 4'd15)     vertical_reg <= vertical_reg + 4'd1;
          else if (controle == 2'b01 && vertical_reg != 4'd0) vertical_reg <= vertical_reg - 4'd1;
          estado_reg <= ST_VERIFICA;
        end
        ST_VERIFICA: begin
          colisoes_reg <= colisoes_next;
          // losing the last life wins over reaching the final column
          if (colisoes_next >= vidas_reg) begin
            estado_reg <= ST_PERDEU;
          end else if (horizontal_reg == 4'(COLUNA_FINAL)) begin
            estado_reg <= ST_VENCEU;
          end else begin
            tick_reg   <= 12'd0;
            estado_reg <= ST_VOO;
          end
        end
        ST_VENCEU, ST_PERDEU: begin
          if (iniciar) estado_reg <= ST_ESCOLHE_MODO;
        end
        default: estado_reg <= ST_INICIAL;
      endcase
    end
  end

  assign venceu                = (estado_reg == ST_VENCEU);
  assign perdeu                = (estado_reg == ST_PERDEU);
  assign db_posicao_horizontal = horizontal_reg;
  assign db_posicao_vertical   = vertical_reg;
  assign db_obstaculos         = obstaculo;
  assign db_estado             = estado_reg;
  assign db_modo               = modo_reg;
  assign colisao_counter_out   = colisoes_reg;

endmodule

// File: tb/tb_simulador_drone.sv
// Testbench for simulador_drone: game-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_simulador_drone;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic [1:0] controle = 2'b00;
  logic       confirma = 1'b0;
  logic       venceu, perdeu;
  logic [3:0] db_posicao_horizontal, db_posicao_vertical, db_obstaculos, db_estado;
  logic [1:0] db_modo;
  logic [2:0] colisao_counter_out;

  int checks = 0;
  int errors = 0;

  simulador_drone dut (
    .clock                 (clk),
    .reset                 (reset),
    .iniciar               (iniciar),
    .controle              (controle),
    .confirma              (confirma),
    .venceu                (venceu),
    .perdeu                (perdeu),
    .db_posicao_horizontal (db_posicao_horizontal),
    .db_posicao_vertical   (db_posicao_vertical),
    .db_obstaculos         (db_obstaculos),
    .db_estado             (db_estado),
    .db_modo               (db_modo),
    .colisao_counter_out   (colisao_counter_out)
  );

  always #5 clk = ~clk;

  // Game phases, numbered as the visible state codes
  localparam int P_INI = 0, P_MODE = 1, P_LIVES = 2, P_PREP = 3, P_FLY = 4,
                 P_MOVE = 5, P_CHECK = 6, P_WON = 8, P_LOST = 9;

  typedef struct {
    int ph;
    int col;
    int row;
    int hits;
    int lives;
    int mode;
    int left;   // flight clocks remaining before the next move
    bit pconf;
    bit pc0;
  } mdl_t;

  mdl_t m;

  function automatic int tick_of(int mode);
    if (mode == 1) return 1000;
    if (mode == 2) return 500;
    return 2000;
  endfunction

  function automatic int obst_of(int mode, int col);
    int r;
    r = 15;
    if (mode == 2) begin
      if (col % 2 == 1) r = 7;
      else if (col == 8) r = 6;
    end else begin
      case (col)
        3: r = 7; 6: r = 9; 9: r = 7; 12: r = 5;
        default: ;
      endcase
      if (mode == 1) begin
        case (col)
          5: r = 7; 10: r = 8; 14: r = 7;
          default: ;
        endcase
      end
    end
    return r;
  endfunction

  function automatic mdl_t model_step(mdl_t cur, bit rst, bit ini, bit [1:0] c, bit conf);
    mdl_t n;
    bit   rise;
    bit   rise0;
    int   h;
    n     = cur;
    rise  = conf && !cur.pconf;
    rise0 = c[0] && !cur.pc0;
    n.pconf = conf;
    n.pc0   = c[0];
    if (rst) begin
      n.ph = P_INI; n.col = 0; n.row = 7; n.hits = 0; n.lives = 1;
      n.mode = 0; n.left = 0; n.pconf = 0; n.pc0 = 0;
      return n;
    end
    case (cur.ph)
      P_INI: if (ini) n.ph = P_MODE;
      P_MODE: if (rise) begin
        n.mode  = (c == 2'b11) ? 0 : int'(c);
        n.lives = 1;
        n.ph    = P_LIVES;
      end
      P_LIVES: begin
        if (rise0 && cur.lives < 7) n.lives = cur.lives + 1;
        if (rise) n.ph = P_PREP;
      end
      P_PREP: begin
        n.col = 0; n.row = 7; n.hits = 0; n.left = tick_of(cur.mode); n.ph = P_FLY;
      end
      P_FLY: begin
        if (cur.left <= 1) n.ph = P_MOVE;
        else n.left = cur.left - 1;
      end
      P_MOVE: begin
        n.col = cur.col + 1;
        if (c == 2'b10) n.row = (cur.row == 15) ? 15 : cur.row + 1;
        else if (c == 2'b01) n.row = (cur.row == 0) ? 0 : cur.row - 1;
        n.ph = P_CHECK;
      end
      P_CHECK: begin
        h = cur.hits;
        if (obst_of(cur.mode, cur.col) != 15 && obst_of(cur.mode, cur.col) == cur.row) h = h + 1;
        n.hits = h;
        if (h >= cur.lives) n.ph = P_LOST;
        else if (cur.col == 15) n.ph = P_WON;
        else begin n.left = tick_of(cur.mode); n.ph = P_FLY; end
      end
      P_WON, P_LOST: if (ini) n.ph = P_MODE;
      default: n.ph = P_INI;
    endcase
    return n;
  endfunction

  // Advance the reference model on each active edge with the same inputs the DUT sees
  always @(posedge clk) m <= model_step(m, reset, iniciar, controle, confirma);

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    if ($time > 6) begin
      check("m_estado",     int'(db_estado),             m.ph);
      check("m_horizontal", int'(db_posicao_horizontal), m.col);
      check("m_vertical",   int'(db_posicao_vertical),   m.row);
      check("m_obst",       int'(db_obstaculos),         obst_of(m.mode, m.col));
      check("m_colisoes",   int'(colisao_counter_out),   m.hits);
      check("m_modo",       int'(db_modo),               m.mode);
      check("m_venceu",     int'(venceu),                (m.ph == P_WON)  ? 1 : 0);
      check("m_perdeu",     int'(perdeu),                (m.ph == P_LOST) ? 1 : 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_estado(input int code, input int budget);
    int k;
    k = 0;
    while (int'(db_estado) != code && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_estado", int'(db_estado), code);
  endtask

  task automatic go_start();
    iniciar = 1'b1; tick(1); iniciar = 1'b0;
  endtask

  // From ESCOLHE_MODO: confirm the mode, give lives pulses, confirm, end on the first VOO cycle
  task automatic choose(input logic [1:0] mode, input int pulses);
    controle = mode; confirma = 1'b1; tick(1);
    confirma = 1'b0; controle = 2'b00; tick(1);
    for (int i = 0; i < pulses; i++) begin
      controle = 2'b01; tick(1);
      controle = 2'b00; tick(1);
    end
    confirma = 1'b1; tick(1);
    confirma = 1'b0; tick(1);
  endtask

  initial begin
    // Reset held for 10 clocks
    tick(10);
    check("rst_estado", int'(db_estado), 0);
    check("rst_horizontal", int'(db_posicao_horizontal), 0);
    check("rst_vertical", int'(db_posicao_vertical), 7);
    check("rst_colisoes", int'(colisao_counter_out), 0);
    check("rst_venceu", int'(venceu), 0);
    check("rst_perdeu", int'(perdeu), 0);
    reset = 1'b0;
    tick(1);

    // Easy, 3 lives, hold: hits at columns 3 and 9, win at column 15 after 15*2002 clocks
    go_start();
    choose(2'b00, 2);
    check("setup_estado", int'(db_estado), 4);
    check("setup_modo", int'(db_modo), 0);
    tick(15 * 2002 - 1);
    check("win_not_yet", int'(venceu), 0);
    tick(1);
    check("win_venceu", int'(venceu), 1);
    check("win_horizontal", int'(db_posicao_horizontal), 15);
    check("win_colisoes", int'(colisao_counter_out), 2);
    $display("game easy/3 lives: estado=%0d col=%0d hits=%0d", db_estado, db_posicao_horizontal, colisao_counter_out);

    // Restart from VENCEU, then easy with 1 life loses at column 3
    go_start();
    check("restart_estado", int'(db_estado), 1);
    choose(2'b00, 0);
    wait_estado(9, 3 * 2002 + 20);
    check("loss_perdeu", int'(perdeu), 1);
    check("loss_horizontal", int'(db_posicao_horizontal), 3);
    check("loss_colisoes", int'(colisao_counter_out), 1);
    tick(50);
    check("loss_frozen", int'(db_posicao_horizontal), 3);
    $display("game easy/1 life: estado=%0d col=%0d hits=%0d", db_estado, db_posicao_horizontal, colisao_counter_out);

    // Easy, 7 lives, steer up for 10 columns: row saturates at 15, no hits
    go_start();
    choose(2'b00, 8);
    controle = 2'b10;
    tick(10 * 2002);
    check("up_vertical", int'(db_posicao_vertical), 15);
    check("up_horizontal", int'(db_posicao_horizontal), 10);
    check("up_colisoes", int'(colisao_counter_out), 0);
    $display("game easy/up: col=%0d row=%0d hits=%0d", db_posicao_horizontal, db_posicao_vertical, colisao_counter_out);

    // Mid-flight reset returns everything to reset values on the next clock
    reset = 1'b1; tick(1);
    check("mrst_estado", int'(db_estado), 0);
    check("mrst_horizontal", int'(db_posicao_horizontal), 0);
    check("mrst_vertical", int'(db_posicao_vertical), 7);
    check("mrst_colisoes", int'(colisao_counter_out), 0);
    check("mrst_modo", int'(db_modo), 0);
    reset = 1'b0; controle = 2'b00; tick(1);

    // Random games: random mode, lives and per-cycle steering/confirm noise
    for (int g = 0; g < 4; g++) begin
      logic [1:0] md;
      int np;
      int k;
      md = 2'($urandom_range(3, 0));
      np = $urandom_range(8, 0);
      go_start();
      choose(md, np);
      k = 0;
      while (!(venceu || perdeu) && k < 4000) begin
        controle = 2'($urandom);
        confirma = 1'($urandom);
        tick(1);
        k++;
      end
      $display("random game %0d mode=%0d pulses=%0d: estado=%0d col=%0d row=%0d hits=%0d cycles=%0d",
               g, md, np, db_estado, db_posicao_horizontal, db_posicao_vertical, colisao_counter_out, k);
      controle = 2'b00; confirma = 1'b0;
      reset = 1'b1; tick(2);
      reset = 1'b0; tick(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
